// File: rtl/circuito_pwm_360_rampa.sv
// Multi-channel PWM generator for continuous-rotation servos. A shared period counter
// drives every channel; each channel's pulse width slews toward its commanded width once per period.
module circuito_pwm_360_rampa #(
    parameter int CANAIS          = 4,
    parameter int conf_periodo    = 1250,
    parameter int largura_parado  = 0,
    parameter int largura_horario = 50,
    parameter int largura_anti    = 100,
    parameter int passo           = 10,
    parameter int W_CONT          = 32,
    localparam int W_CANAL        = (CANAIS > 1) ? $clog2(CANAIS) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valido,
    input  logic [W_CANAL-1:0] cmd_canal,
    input  logic [1:0]         cmd_codigo,
    output logic [CANAIS-1:0]  pwm,
    output logic               inicio_periodo,
    output logic [CANAIS-1:0]  estavel
);

    localparam logic [W_CONT-1:0] L_PARADO   = W_CONT'(largura_parado);
    localparam logic [W_CONT-1:0] L_HORARIO  = W_CONT'(largura_horario);
    localparam logic [W_CONT-1:0] L_ANTI     = W_CONT'(largura_anti);
    localparam logic [W_CONT-1:0] L_PASSO    = W_CONT'(passo);
    localparam logic [W_CONT-1:0] ULTIMA     = W_CONT'(conf_periodo - 1);

    logic [W_CONT-1:0] contagem;
    logic [W_CONT-1:0] alvo  [CANAIS];
    logic [W_CONT-1:0] atual [CANAIS];
    logic              fronteira;
    logic              cmd_aceito;

    function automatic logic [W_CONT-1:0] largura_cmd(input logic [1:0] codigo);
        case (codigo)
            2'b01:   return L_HORARIO;
            2'b10:   return L_ANTI;
            default: return L_PARADO;
        endcase
    endfunction

    // Both directions compare the distance against the step first, so neither
    // the add can overshoot the target nor the subtract wrap below zero.
    function automatic logic [W_CONT-1:0] rampa(input logic [W_CONT-1:0] a,
                                                input logic [W_CONT-1:0] t);
        if (L_PASSO == '0) return t;
        if (a < t)         return ((t - a) <= L_PASSO) ? t : a + L_PASSO;
        if (a > t)         return ((a - t) <= L_PASSO) ? t : a - L_PASSO;
        return a;
    endfunction

    assign fronteira  = (contagem == ULTIMA);
    assign cmd_aceito = cmd_valido && (32'(cmd_canal) < CANAIS);

    // NOTE: non-blocking assignments make the ramp read alvo as it was before this
    // edge's command write, so a strobe on the boundary waits one full period.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem       <= '0;
            inicio_periodo <= 1'b0;
            pwm            <= '0;
            // NOTE: the width arrays are small per-channel registers, not RAM, so
            // resetting them is cheap and needed for a known stop state.
            for (int i = 0; i < CANAIS; i++) begin
                alvo[i]  <= L_PARADO;
                atual[i] <= L_PARADO;
            end
        end else begin
            contagem       <= fronteira ? '0 : contagem + 1'b1;
            inicio_periodo <= fronteira;
            for (int i = 0; i < CANAIS; i++) begin
                pwm[i] <= (contagem < atual[i]);
                if (fronteira)
                    atual[i] <= rampa(atual[i], alvo[i]);
            end
            if (cmd_aceito)
                alvo[cmd_canal] <= largura_cmd(cmd_codigo);
        end
    end

    // NOTE: default assigned first so no path through the block can infer a latch.
    always_comb begin
        estavel = '0;
        for (int i = 0; i < CANAIS; i++)
            estavel[i] = (atual[i] == alvo[i]);
    end

endmodule

// File: tb/tb_circuito_pwm_360_rampa.sv
// Directed bench: dut_a exercises ramping on two channels; dut_b (three channels,
// no ramp) covers out-of-range channel strobes and the direct-jump mode.
module tb_circuito_pwm_360_rampa;

    localparam int P = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       a_valido = 1'b0;
    logic       a_canal  = 1'b0;
    logic [1:0] a_codigo = 2'b00;
    logic [1:0] a_pwm;
    logic       a_inicio;
    logic [1:0] a_estavel;

    logic       b_valido = 1'b0;
    logic [1:0] b_canal  = 2'b00;
    logic [1:0] b_codigo = 2'b00;
    logic [2:0] b_pwm;
    logic       b_inicio;
    logic [2:0] b_estavel;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    circuito_pwm_360_rampa #(
        .CANAIS(2), .conf_periodo(P), .largura_parado(0), .largura_horario(6),
        .largura_anti(16), .passo(2), .W_CONT(8)
    ) dut_a (
        .clock(clock), .reset(reset), .cmd_valido(a_valido), .cmd_canal(a_canal),
        .cmd_codigo(a_codigo), .pwm(a_pwm), .inicio_periodo(a_inicio), .estavel(a_estavel)
    );

    circuito_pwm_360_rampa #(
        .CANAIS(3), .conf_periodo(P), .largura_parado(0), .largura_horario(6),
        .largura_anti(16), .passo(0), .W_CONT(8)
    ) dut_b (
        .clock(clock), .reset(reset), .cmd_valido(b_valido), .cmd_canal(b_canal),
        .cmd_codigo(b_codigo), .pwm(b_pwm), .inicio_periodo(b_inicio), .estavel(b_estavel)
    );

    task automatic wait_inicio(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (a_inicio !== 1'b1 && cyc < 200);
    endtask

    task automatic drive_a(input int idx, input int n_cmd, input logic canal,
                           input logic [3:0] codes);
        if (idx >= 0 && idx < n_cmd) begin
            a_valido = 1'b1;
            a_canal  = canal;
            a_codigo = codes[2*idx +: 2];
        end else begin
            a_valido = 1'b0;
        end
    endtask

    // Starts on the negedge of an inicio_periodo cycle, counts pwm highs over one
    // period window and ends on the next inicio_periodo cycle.
    task automatic run_period(input int cmd_at, input int n_cmd, input logic canal,
                              input logic [3:0] codes, output int h0, output int h1,
                              output logic [1:0] ef, output logic [1:0] ee);
        h0 = 0;
        h1 = 0;
        ef = '0;
        drive_a(cmd_at < 0 ? -1 : 0 - cmd_at, n_cmd, canal, codes);
        for (int c = 1; c <= P; c++) begin
            @(negedge clock);
            h0 += int'(a_pwm[0]);
            h1 += int'(a_pwm[1]);
            if (c == 1) ef = a_estavel;
            drive_a(cmd_at < 0 ? -1 : c - cmd_at, n_cmd, canal, codes);
        end
        ee = a_estavel;
        n_checks++;
        if (a_inicio !== 1'b1) $display("FAIL period_sync: inicio_periodo=%b required 1", a_inicio);
        else n_pass++;
    endtask

    task automatic test_reset;
        int cyc;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (a_pwm !== 2'b00) $display("FAIL reset_pwm: got %b required 00", a_pwm); else n_pass++;
        n_checks++;
        if (a_estavel !== 2'b11) $display("FAIL reset_estavel: got %b required 11", a_estavel); else n_pass++;
        n_checks++;
        if (a_inicio !== 1'b0) $display("FAIL reset_inicio: got %b required 0", a_inicio); else n_pass++;
        n_checks++;
        if (b_estavel !== 3'b111) $display("FAIL reset_estavel_b: got %b required 111", b_estavel); else n_pass++;
        reset = 1'b0;
        wait_inicio(cyc);
        n_checks++;
        if (cyc !== 20) $display("FAIL first_inicio: got %0d cycles required 20", cyc); else n_pass++;
        wait_inicio(cyc);
        n_checks++;
        if (cyc !== 20) $display("FAIL second_inicio: got %0d cycles required 20", cyc); else n_pass++;
    endtask

    task automatic test_soft_start;
        int h0, h1;
        logic [1:0] ef, ee;
        int exp0[5] = '{0, 2, 4, 6, 6};
        for (int k = 0; k < 5; k++) begin
            run_period(k == 0 ? 0 : -1, 1, 1'b0, 4'b0001, h0, h1, ef, ee);
            n_checks++;
            if (h0 !== exp0[k]) $display("FAIL soft_start_h0[%0d]: got %0d required %0d", k, h0, exp0[k]);
            else n_pass++;
            n_checks++;
            if (h1 !== 0) $display("FAIL soft_start_h1[%0d]: got %0d required 0", k, h1); else n_pass++;
            if (k == 0) begin
                n_checks++;
                if (ef !== 2'b10) $display("FAIL soft_start_estavel_fall: got %b required 10", ef); else n_pass++;
            end
            if (k == 1) begin
                n_checks++;
                if (ee !== 2'b10) $display("FAIL soft_start_estavel_mid: got %b required 10", ee); else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if (ee !== 2'b11) $display("FAIL soft_start_estavel_rise: got %b required 11", ee); else n_pass++;
            end
        end
    endtask

    task automatic test_reversal;
        int h0, h1;
        logic [1:0] ef, ee;
        int exp_up[7]    = '{6, 8, 10, 12, 14, 16, 16};
        int exp_down[10] = '{16, 14, 12, 10, 8, 6, 4, 2, 0, 0};
        for (int k = 0; k < 7; k++) begin
            run_period(k == 0 ? 0 : -1, 1, 1'b0, 4'b0010, h0, h1, ef, ee);
            n_checks++;
            if (h0 !== exp_up[k]) $display("FAIL reversal_up[%0d]: got %0d required %0d", k, h0, exp_up[k]);
            else n_pass++;
        end
        n_checks++;
        if (ee !== 2'b11) $display("FAIL reversal_up_estavel: got %b required 11", ee); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            run_period(k == 0 ? 0 : -1, 1, 1'b0, 4'b0000, h0, h1, ef, ee);
            n_checks++;
            if (h0 !== exp_down[k]) $display("FAIL reversal_down[%0d]: got %0d required %0d", k, h0, exp_down[k]);
            else n_pass++;
        end
        n_checks++;
        if (ee !== 2'b11) $display("FAIL reversal_down_estavel: got %b required 11", ee); else n_pass++;
    endtask

    task automatic test_edge_commands;
        int h0, h1, e1;
        logic [1:0] ef, ee;
        // Strobe on the boundary edge (contagem = 19).
        run_period(19, 1, 1'b0, 4'b0001, h0, h1, ef, ee);
        n_checks++;
        if (h0 !== 0) $display("FAIL boundary_cmd_p0: got %0d required 0", h0); else n_pass++;
        n_checks++;
        if (ee !== 2'b10) $display("FAIL boundary_cmd_estavel: got %b required 10", ee); else n_pass++;
        run_period(-1, 0, 1'b0, 4'b0000, h0, h1, ef, ee);
        n_checks++;
        if (h0 !== 0) $display("FAIL boundary_cmd_p1: got %0d required 0", h0); else n_pass++;
        run_period(-1, 0, 1'b0, 4'b0000, h0, h1, ef, ee);
        n_checks++;
        if (h0 !== 2) $display("FAIL boundary_cmd_p2: got %0d required 2", h0); else n_pass++;
        // Back-to-back strobes to ch1: 01 then 10, the later one must win.
        for (int k = 0; k < 9; k++) begin
            run_period(k == 0 ? 0 : -1, 2, 1'b1, 4'b1001, h0, h1, ef, ee);
            e1 = (2 * k > 16) ? 16 : 2 * k;
            n_checks++;
            if (h1 !== e1) $display("FAIL back_to_back_h1[%0d]: got %0d required %0d", k, h1, e1);
            else n_pass++;
            n_checks++;
            if (h0 !== (k == 0 ? 4 : 6)) $display("FAIL back_to_back_h0[%0d]: got %0d required %0d", k, h0, k == 0 ? 4 : 6);
            else n_pass++;
            if (k == 7) begin
                n_checks++;
                if (ee !== 2'b11) $display("FAIL back_to_back_estavel: got %b required 11", ee); else n_pass++;
            end
        end
    endtask

    task automatic test_invalid_channel;
        int hb;
        int est_bad;
        hb = 0;
        est_bad = 0;
        b_valido = 1'b1;
        b_canal  = 2'd3;
        b_codigo = 2'b10;
        for (int c = 1; c <= 2 * P; c++) begin
            @(negedge clock);
            b_valido = 1'b0;
            hb += int'(b_pwm[0]) + int'(b_pwm[1]) + int'(b_pwm[2]);
            if (b_estavel !== 3'b111) est_bad++;
        end
        n_checks++;
        if (hb !== 0) $display("FAIL invalid_channel_pwm: got %0d high cycles required 0", hb); else n_pass++;
        n_checks++;
        if (est_bad !== 0) $display("FAIL invalid_channel_estavel: got %0d unstable cycles required 0", est_bad);
        else n_pass++;
    endtask

    // Entered right after test_invalid_channel, which ends on an inicio_periodo cycle.
    task automatic test_no_ramp;
        int h2, hlow;
        logic [2:0] ef;
        h2 = 0;
        hlow = 0;
        ef = '0;
        b_valido = 1'b1;
        b_canal  = 2'd2;
        b_codigo = 2'b10;
        for (int c = 1; c <= P; c++) begin
            @(negedge clock);
            b_valido = 1'b0;
            h2 += int'(b_pwm[2]);
            if (c == 1) ef = b_estavel;
        end
        n_checks++;
        if (h2 !== 0) $display("FAIL no_ramp_p0: got %0d required 0", h2); else n_pass++;
        n_checks++;
        if (ef !== 3'b011) $display("FAIL no_ramp_estavel_fall: got %b required 011", ef); else n_pass++;
        h2 = 0;
        for (int c = 1; c <= P; c++) begin
            @(negedge clock);
            h2 += int'(b_pwm[2]);
            hlow += int'(b_pwm[0]) + int'(b_pwm[1]);
        end
        n_checks++;
        if (h2 !== 16) $display("FAIL no_ramp_p1: got %0d required 16", h2); else n_pass++;
        n_checks++;
        if (hlow !== 0) $display("FAIL no_ramp_other: got %0d required 0", hlow); else n_pass++;
        n_checks++;
        if (b_estavel !== 3'b111) $display("FAIL no_ramp_estavel: got %b required 111", b_estavel); else n_pass++;
    endtask

    task automatic test_reset_mid_ramp;
        int h0, h1, cyc;
        logic [1:0] ef, ee;
        run_period(0, 1, 1'b0, 4'b0010, h0, h1, ef, ee);
        n_checks++;
        if (h0 !== 6) $display("FAIL mid_ramp_pre: got %0d required 6", h0); else n_pass++;
        repeat (7) @(negedge clock);
        n_checks++;
        if (a_pwm !== 2'b11) $display("FAIL mid_ramp_pwm_before: got %b required 11", a_pwm); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (a_pwm !== 2'b00) $display("FAIL mid_ramp_pwm: got %b required 00", a_pwm); else n_pass++;
        n_checks++;
        if (a_estavel !== 2'b11) $display("FAIL mid_ramp_estavel: got %b required 11", a_estavel); else n_pass++;
        n_checks++;
        if (a_inicio !== 1'b0) $display("FAIL mid_ramp_inicio: got %b required 0", a_inicio); else n_pass++;
        wait_inicio(cyc);
        n_checks++;
        if (cyc !== 20) $display("FAIL mid_ramp_contagem: got %0d cycles to wrap required 20", cyc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_soft_start();
        test_reversal();
        test_edge_commands();
        test_invalid_channel();
        test_no_ramp();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
